// File: rtl/register_file_pkg.sv
// Shared y86 constants: register IDs, register count and word width.
// Imported by the register file and by decode so both agree on the encoding.
package register_file_pkg;

    localparam int WORD_W   = 64;
    localparam int ID_W     = 4;
    localparam int NUM_REGS = 15;

    localparam logic [ID_W-1:0] RRSP  = 4'h4;
    localparam logic [ID_W-1:0] RNONE = 4'hF;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ID_W-1:0]   regId_t;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } haltState_t;

    // RNONE is the "no register" encoding on every port.
    function automatic logic isReg(input regId_t id);
        return id != RNONE;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/execute/memory-to-register-file bundle: read IDs, write ports,
// debug read and status outputs.
interface register_file_if;
    import register_file_pkg::*;

    regId_t      srcA;
    regId_t      srcB;
    regId_t      dstE;
    regId_t      dstM;
    word_t       valE;
    word_t       valM;
    logic        wb_en;
    logic        halt;
    regId_t      dbg_sel;
    word_t       valA;
    word_t       valB;
    word_t       dbg_val;
    logic        halted;
    logic [31:0] wr_count;

    modport master (
        output srcA, srcB, dstE, dstM, valE, valM, wb_en, halt, dbg_sel,
        input  valA, valB, dbg_val, halted, wr_count
    );

    modport slave (
        input  srcA, srcB, dstE, dstM, valE, valM, wb_en, halt, dbg_sel,
        output valA, valB, dbg_val, halted, wr_count
    );

endinterface

// File: rtl/register_file.sv
// y86 register file: 15 x 64-bit registers, two async read ports plus debug
// read, E/M write ports with M priority, sticky halt and committed-write count.
module register_file
    import register_file_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave rf
);

    word_t       regsReg  [NUM_REGS];
    word_t       regsNext [NUM_REGS];
    logic [31:0] wrCountReg;
    logic [31:0] wrCountNext;
    haltState_t  stateReg;
    haltState_t  stateNext;

    logic        haltedNow;
    logic        writeOk;
    logic        wrE;
    logic        wrM;
    logic [1:0]  numWrites;

    assign haltedNow = (stateReg == ST_HALTED);
    assign writeOk   = rf.wb_en & ~rf.halt & ~haltedNow;

    // A shared destination (popq %rsp) is a single write of valM, so the E
    // port is dropped rather than counted.
    assign wrM       = writeOk & isReg(rf.dstM);
    assign wrE       = writeOk & isReg(rf.dstE) & ~(wrM && (rf.dstE == rf.dstM));
    assign numWrites = {1'b0, wrE} + {1'b0, wrM};

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regNext
            localparam regId_t ID = regId_t'(gi);
            assign regsNext[gi] = (wrM && rf.dstM == ID) ? rf.valM :
                                  (wrE && rf.dstE == ID) ? rf.valE :
                                  regsReg[gi];
        end
    endgenerate

    assign wrCountNext = wrCountReg + {30'd0, numWrites};

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_RUN:    if (rf.halt) stateNext = ST_HALTED;
            ST_HALTED: stateNext = ST_HALTED;
            default:   stateNext = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regsReg[i] <= '0;
            end
            wrCountReg <= '0;
            stateReg   <= ST_RUN;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regsReg[i] <= regsNext[i];
            end
            wrCountReg <= wrCountNext;
            stateReg   <= stateNext;
        end
    end

    // Reads see pre-edge state only; no bypass from the write ports.
    assign rf.valA     = (rf.srcA    == RNONE) ? '0 : regsReg[rf.srcA];
    assign rf.valB     = (rf.srcB    == RNONE) ? '0 : regsReg[rf.srcB];
    assign rf.dbg_val  = (rf.dbg_sel == RNONE) ? '0 : regsReg[rf.dbg_sel];
    assign rf.halted   = haltedNow;
    assign rf.wr_count = wrCountReg;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a table of single-cycle vectors checked
// after each edge, plus hand sequences for bypass, halt and reset corners.
module tb_register_file;
    import register_file_pkg::*;

    logic clk = 1'b0;
    logic rst;
    register_file_if rfIf();

    register_file dut (
        .clk(clk),
        .rst(rst),
        .rf (rfIf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [63:0] valE;
        logic [63:0] valM;
        logic        wbEn;
        logic [3:0]  dbgSel;
        logic [63:0] expA;
        logic [63:0] expB;
        logic [63:0] expDbg;
        logic        expHalted;
        logic [31:0] expCount;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sA, input logic [3:0] sB, input logic [3:0] dE,
                         input logic [3:0] dM, input logic [63:0] vE, input logic [63:0] vM,
                         input logic wb, input logic h, input logic [3:0] dbg);
        rfIf.srcA    = sA;
        rfIf.srcB    = sB;
        rfIf.dstE    = dE;
        rfIf.dstM    = dM;
        rfIf.valE    = vE;
        rfIf.valM    = vM;
        rfIf.wb_en   = wb;
        rfIf.halt    = h;
        rfIf.dbg_sel = dbg;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'h2, 4'hF, 4'h2, 4'hF, 64'h5,   64'h0,   1'b1, 4'hF,
                    64'h5, 64'h0, 64'h0, 1'b0, 32'd1};
        vecs[1] = '{4'h4, 4'h2, 4'h4, 4'h4, 64'h100, 64'h200, 1'b1, 4'h4,
                    64'h200, 64'h5, 64'h200, 1'b0, 32'd2};
        vecs[2] = '{4'h5, 4'hF, 4'h5, 4'hF, 64'hAA,  64'h0,   1'b0, 4'hF,
                    64'h0, 64'h0, 64'h0, 1'b0, 32'd2};
        vecs[3] = '{4'h7, 4'h8, 4'h7, 4'h8, 64'h11,  64'h22,  1'b1, 4'h2,
                    64'h11, 64'h22, 64'h5, 1'b0, 32'd4};
        vecs[4] = '{4'hF, 4'hF, 4'hF, 4'hF, 64'hDEAD, 64'hBEEF, 1'b1, 4'hF,
                    64'h0, 64'h0, 64'h0, 1'b0, 32'd4};
        vecs[5] = '{4'hE, 4'h0, 4'hE, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 4'h7,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h11, 1'b0, 32'd6};
        vecs[6] = '{4'h3, 4'h4, 4'hF, 4'h3, 64'h0,   64'h33,  1'b1, 4'hE,
                    64'h33, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'd7};

        // Reset state
        rst = 1'b1;
        drive(4'h0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0, 4'h4);
        stepEdge();
        stepEdge();
        rst = 1'b0;
        check("reset_valA", rfIf.valA, 64'h0);
        check("reset_halted", {63'h0, rfIf.halted}, 64'h0);
        check("reset_count", {32'h0, rfIf.wr_count}, 64'h0);
        $display("reset: valA=%h halted=%0d wr_count=%0d", rfIf.valA, rfIf.halted, rfIf.wr_count);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].srcA, vecs[i].srcB, vecs[i].dstE, vecs[i].dstM,
                  vecs[i].valE, vecs[i].valM, vecs[i].wbEn, 1'b0, vecs[i].dbgSel);
            stepEdge();
            check($sformatf("vec%0d_valA", i), rfIf.valA, vecs[i].expA);
            check($sformatf("vec%0d_valB", i), rfIf.valB, vecs[i].expB);
            check($sformatf("vec%0d_dbg", i), rfIf.dbg_val, vecs[i].expDbg);
            check($sformatf("vec%0d_halted", i), {63'h0, rfIf.halted}, {63'h0, vecs[i].expHalted});
            check($sformatf("vec%0d_count", i), {32'h0, rfIf.wr_count}, {32'h0, vecs[i].expCount});
            $display("vec%0d: dstE=%h dstM=%h wb=%0d -> valA=%h valB=%h dbg=%h cnt=%0d",
                     i, vecs[i].dstE, vecs[i].dstM, vecs[i].wbEn,
                     rfIf.valA, rfIf.valB, rfIf.dbg_val, rfIf.wr_count);
        end

        // Same-cycle write is not bypassed to the read port
        drive(4'h1, 4'hF, 4'h1, 4'hF, 64'h7, 64'h0, 1'b1, 1'b0, 4'hF);
        #1;
        check("nobypass_before", rfIf.valA, 64'h0);
        stepEdge();
        check("nobypass_after", rfIf.valA, 64'h7);
        check("nobypass_count", {32'h0, rfIf.wr_count}, 64'd8);
        $display("bypass: reg1 after edge=%h cnt=%0d", rfIf.valA, rfIf.wr_count);

        // Halting instruction's own write is suppressed, then halted is sticky
        drive(4'h3, 4'hF, 4'h3, 4'hF, 64'h9, 64'h0, 1'b1, 1'b1, 4'hF);
        stepEdge();
        check("halt_reg3", rfIf.valA, 64'h33);
        check("halt_flag", {63'h0, rfIf.halted}, 64'h1);
        check("halt_count", {32'h0, rfIf.wr_count}, 64'd8);
        $display("halt: reg3=%h halted=%0d cnt=%0d", rfIf.valA, rfIf.halted, rfIf.wr_count);
        drive(4'h3, 4'hF, 4'h3, 4'h9, 64'h99, 64'h1, 1'b1, 1'b0, 4'h9);
        stepEdge();
        check("halted_reg3", rfIf.valA, 64'h33);
        check("halted_reg9", rfIf.dbg_val, 64'h0);
        check("halted_sticky", {63'h0, rfIf.halted}, 64'h1);
        check("halted_count", {32'h0, rfIf.wr_count}, 64'd8);
        $display("post-halt write: reg3=%h reg9=%h halted=%0d cnt=%0d",
                 rfIf.valA, rfIf.dbg_val, rfIf.halted, rfIf.wr_count);

        // Reset wins over a simultaneous write
        rst = 1'b1;
        drive(4'h6, 4'h3, 4'hF, 4'h6, 64'h0, 64'h66, 1'b1, 1'b0, 4'h7);
        stepEdge();
        rst = 1'b0;
        check("rstwr_reg6", rfIf.valA, 64'h0);
        check("rstwr_reg3", rfIf.valB, 64'h0);
        check("rstwr_halted", {63'h0, rfIf.halted}, 64'h0);
        check("rstwr_count", {32'h0, rfIf.wr_count}, 64'h0);
        $display("reset+write: reg6=%h halted=%0d cnt=%0d", rfIf.valA, rfIf.halted, rfIf.wr_count);

        // Every ID reads zero after reset
        rfIf.wb_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rfIf.srcA    = 4'(i);
            rfIf.srcB    = 4'(15 - i);
            rfIf.dbg_sel = 4'(i);
            #1;
            check($sformatf("clear_id%0d", i), rfIf.valA | rfIf.valB | rfIf.dbg_val, 64'h0);
        end
        $display("post-reset sweep: all IDs checked");

        // Writes work again once reset is released
        drive(4'h6, 4'hF, 4'hF, 4'h6, 64'h0, 64'h66, 1'b1, 1'b0, 4'hF);
        stepEdge();
        check("resume_reg6", rfIf.valA, 64'h66);
        check("resume_count", {32'h0, rfIf.wr_count}, 64'd1);
        $display("resume: reg6=%h cnt=%0d", rfIf.valA, rfIf.wr_count);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have srcA, input, 4, read-port A register ID from decode; 4'hF means none.
REQ-004 SHALL have srcB, input, 4, read-port B register ID from decode; 4'hF means none.
REQ-005 SHALL have dstE, input, 4, E write-port register ID from decode; 4'hF means none.
REQ-006 SHALL have dstM, input, 4, M write-port register ID from decode; 4'hF means none.
REQ-007 SHALL have valE, input, 64, E write data from execute.
REQ-008 SHALL have valM, input, 64, M write data from memory.
REQ-009 SHALL have wb_en, input, 1, instruction status OK; writes are committed only when high.
REQ-010 SHALL have halt, input, 1, current instruction is halt or has a faulting status.
REQ-011 SHALL have dbg_sel, input, 4, debug read register ID.
REQ-012 SHALL have valA, output, 64, contents of srcA.
REQ-013 SHALL have valB, output, 64, contents of srcB.
REQ-014 SHALL have dbg_val, output, 64, contents of dbg_sel.
REQ-015 SHALL have halted, output, 1, sticky halted flag.
REQ-016 SHALL have wr_count, output, 32, count of committed register writes.

Function
REQ-017 SHALL hold 15 64-bit registers, IDs 0x0-0xE (0x4 = %rsp).
REQ-018 SHALL drive valA, valB and dbg_val combinationally from current state; ID 4'hF reads 64'h0.
REQ-019 SHALL not bypass same-cycle writes to the read ports; a read returns the pre-edge value.
REQ-020 SHALL define write_ok = wb_en & ~halt & ~halted.
REQ-021 SHALL write valE to dstE at the rising edge when write_ok and dstE != 4'hF.
REQ-022 SHALL write valM to dstM at the rising edge when write_ok and dstM != 4'hF.
REQ-023 SHALL give M priority when dstE == dstM != 4'hF: only valM is stored (popq %rsp case).
REQ-024 SHALL increment wr_count by the number of distinct registers written that cycle (0, 1 or 2), wrapping modulo 2^32.
REQ-025 SHALL set halted at the rising edge when halt is high; once set it stays high until rst.
REQ-026 SHALL suppress the writes of the halting instruction itself (halt high blocks that cycle).
REQ-027 SHALL have single-cycle write latency: a value written at edge N is visible on the read ports after edge N.

Reset
REQ-028 SHALL clear all 15 registers, halted and wr_count to 0 on any clk edge with rst high.
REQ-029 SHALL give rst priority over any simultaneous write or halt; a reset mid-program discards that cycle's writes.
REQ-030 SHALL drive valA/valB/dbg_val to 0 for all IDs in the cycle after reset.

Structure
REQ-031 SHALL take the register IDs (RRSP = 4'h4, RNONE = 4'hF), the register count and the 64-bit word width from a shared y86 constants package, also used by decode.
REQ-032 SHALL be a single module with no sub-modules; the storage is a 15-entry array.

Verification
REQ-033 SHALL cover this scenario: reset, then dstE=2, valE=64'h5, wb_en=1 for one cycle, then srcA=2 -> valA=5 and wr_count=1.
REQ-034 SHALL cover this scenario: dstE=4, dstM=4, valE=64'h100, valM=64'h200, wb_en=1 -> reg4=64'h200 and wr_count increments by 1.
REQ-035 SHALL cover this scenario: dstE=1, valE=64'h7, with srcA=1 in the same cycle -> valA shows the old value before the edge and 7 after it.
REQ-036 SHALL cover this scenario: halt=1 with dstE=3, valE=64'h9 -> reg3 unchanged and halted=1; later writes with wb_en=1 are ignored; after rst, halted=0.
REQ-037 SHALL cover this scenario: srcA=4'hF, srcB=4'hF and dbg_sel=4'hF -> all three outputs are 0; dstE=4'hF, dstM=4'hF -> no state change and wr_count unchanged.
REQ-038 SHALL cover this scenario: wb_en=0 with dstE=5 -> reg5 unchanged; rst asserted together with dstM=6 write -> reg6=0.
